// File: rtl/id_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_decode_pipe
// Purpose  : Instruction decode stage with a one-entry valid/ready output
//            register, NREG x XLEN register file with write-back port and
//            sign-extended immediate generation.
// Options  : define ID_WB_BYPASS_EN to forward a same-cycle write-back value
//            to the operands read at accept time.
// Revision : 1.0 - initial release
// ============================================================================
module id_decode_pipe #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] data1,
    output logic [XLEN-1:0] data2,
    output logic [XLEN-1:0] imm_ext
);

    localparam int         c_addr_w = $clog2(NREG);
    localparam logic [5:0] c_nreg   = 6'(NREG);

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_imm32  = 7'b0011011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_system = 7'b1110011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    logic [XLEN-1:0] r_regs [NREG];
    logic            r_out_valid;
    logic [6:0]      r_opcode;
    logic [4:0]      r_rd;
    logic [2:0]      r_func3;
    logic [6:0]      r_func7;
    logic [4:0]      r_rs1_addr;
    logic [4:0]      r_rs2_addr;
    logic [XLEN-1:0] r_data1;
    logic [XLEN-1:0] r_data2;
    logic [XLEN-1:0] r_imm_ext;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_wb_write;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm_ext;

    assign w_in_ready = rst & (~r_out_valid | out_ready);
    assign w_accept   = in_valid & w_in_ready;
    assign w_rs1      = inst[19:15];
    assign w_rs2      = inst[24:20];

    // x0 and out-of-range destinations are never written; reset blocks writes.
    assign w_wb_write = rst & wb_en & (wb_rd != 5'd0) & ({1'b0, wb_rd} < c_nreg);

    // Register file read: x0 and addresses beyond NREG read as zero.
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if ((w_rs1 != 5'd0) && ({1'b0, w_rs1} < c_nreg)) begin
            w_rs1_val = r_regs[w_rs1[c_addr_w-1:0]];
        end
        if ((w_rs2 != 5'd0) && ({1'b0, w_rs2} < c_nreg)) begin
            w_rs2_val = r_regs[w_rs2[c_addr_w-1:0]];
        end
    end

`ifdef ID_WB_BYPASS_EN
    // Forward a write-back landing this cycle onto the operands being sampled.
    always_comb begin
        w_op1 = w_rs1_val;
        w_op2 = w_rs2_val;
        if (w_wb_write && (wb_rd == w_rs1)) begin
            w_op1 = wb_data;
        end
        if (w_wb_write && (wb_rd == w_rs2)) begin
            w_op2 = wb_data;
        end
    end
`else
    assign w_op1 = w_rs1_val;
    assign w_op2 = w_rs2_val;
`endif

    // Immediate assembly per instruction format, sign-extended to 32 bits.
    always_comb begin
        w_imm32 = 32'd0;
        case (inst[6:0])
            c_op_load, c_op_imm, c_op_imm32, c_op_jalr, c_op_system:
                w_imm32 = {{20{inst[31]}}, inst[31:20]};
            c_op_store:
                w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            c_op_branch:
                w_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            c_op_lui, c_op_auipc:
                w_imm32 = {inst[31:12], 12'd0};
            c_op_jal:
                w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                w_imm32 = 32'd0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_imm_wide
            assign w_imm_ext = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_imm_narrow
            assign w_imm_ext = w_imm32[XLEN-1:0];
        end
    endgenerate

    // Register file: cleared on reset, written independently of pipeline state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_write) begin
            r_regs[wb_rd[c_addr_w-1:0]] <= wb_data;
        end
    end

    // Output bundle register: flush wins over accept, fields hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_rd        <= '0;
            r_func3     <= '0;
            r_func7     <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_data1     <= '0;
            r_data2     <= '0;
            r_imm_ext   <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_opcode    <= inst[6:0];
            r_rd        <= inst[11:7];
            r_func3     <= inst[14:12];
            r_func7     <= inst[31:25];
            r_rs1_addr  <= w_rs1;
            r_rs2_addr  <= w_rs2;
            r_data1     <= w_op1;
            r_data2     <= w_op2;
            r_imm_ext   <= w_imm_ext;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign opcode    = r_opcode;
    assign rd        = r_rd;
    assign func3     = r_func3;
    assign func7     = r_func7;
    assign rs1_addr  = r_rs1_addr;
    assign rs2_addr  = r_rs2_addr;
    assign data1     = r_data1;
    assign data2     = r_data2;
    assign imm_ext   = r_imm_ext;

endmodule
`default_nettype wire

// File: tb/tb_id_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_decode_pipe
// Purpose  : Scoreboard bench for id_decode_pipe. Two instances (64-bit/32
//            registers and 32-bit/16 registers) share one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_decode_pipe;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] data1;
        logic [63:0] data2;
        logic [63:0] imm;
    } bundle_t;

`ifdef ID_WB_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] inst;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [6:0]  opcode_a, func7_a, opcode_b, func7_b;
    logic [4:0]  rd_a, rs1_a, rs2_a, rd_b, rs1_b, rs2_b;
    logic [2:0]  func3_a, func3_b;
    logic [63:0] data1_a, data2_a, imm_a;
    logic [31:0] data1_b, data2_b, imm_b;

    id_decode_pipe #(.XLEN(64), .NREG(32)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .inst(inst), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .opcode(opcode_a), .rd(rd_a), .func3(func3_a), .func7(func7_a),
        .rs1_addr(rs1_a), .rs2_addr(rs2_a), .data1(data1_a), .data2(data2_a),
        .imm_ext(imm_a)
    );

    id_decode_pipe #(.XLEN(32), .NREG(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .inst(inst), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data[31:0]), .out_valid(out_valid_b), .out_ready(out_ready),
        .opcode(opcode_b), .rd(rd_b), .func3(func3_b), .func7(func7_b),
        .rs1_addr(rs1_b), .rs2_addr(rs2_b), .data1(data1_b), .data2(data2_b),
        .imm_ext(imm_b)
    );

    bundle_t obs [2];
    logic    vld [2];
    logic    rdy [2];

    assign obs[0] = {opcode_a, rd_a, func3_a, func7_a, rs1_a, rs2_a, data1_a, data2_a, imm_a};
    assign obs[1] = {opcode_b, rd_b, func3_b, func7_b, rs1_b, rs2_b,
                     32'd0, data1_b, 32'd0, data2_b, 32'd0, imm_b};
    assign vld[0] = out_valid_a;
    assign vld[1] = out_valid_b;
    assign rdy[0] = in_ready_a;
    assign rdy[1] = in_ready_b;

    // Reference state: expected bundles in flight and architectural registers.
    bundle_t     exp_q [2][$];
    logic [63:0] mregs [2][32];

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int nreg_of(input int k);
        return (k == 1) ? 16 : 32;
    endfunction

    function automatic logic [63:0] fit(input int k, input logic [63:0] v);
        return (k == 1) ? {32'd0, v[31:0]} : v;
    endfunction

    function automatic bit wr_ok(input int k);
        return rst && wb_en && (wb_rd != 5'd0) && (int'(wb_rd) < nreg_of(k));
    endfunction

    function automatic logic [63:0] read_op(input int k, input logic [4:0] r);
        logic [63:0] v;
        v = (r == 5'd0 || int'(r) >= nreg_of(k)) ? 64'd0 : mregs[k][r];
        if (c_bypass && wr_ok(k) && wb_rd == r) v = fit(k, wb_data);
        return v;
    endfunction

    // Immediate value as a signed number, scaled by the format's implied zeros.
    function automatic logic [63:0] ref_imm(input logic [31:0] i);
        longint v;
        logic [6:0] op;
        op = i[6:0];
        v = 0;
        if (op == 7'b0000011 || op == 7'b0010011 || op == 7'b0011011 ||
            op == 7'b1100111 || op == 7'b1110011)
            v = longint'($signed(i[31:20]));
        else if (op == 7'b0100011)
            v = longint'($signed({i[31:25], i[11:7]}));
        else if (op == 7'b1100011)
            v = longint'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
        else if (op == 7'b0110111 || op == 7'b0010111)
            v = longint'($signed(i[31:12])) * 4096;
        else if (op == 7'b1101111)
            v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
        return v;
    endfunction

    task automatic chk(input string name, input int k, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, k, got, exp);
        end
    endtask

    // Model: predict acceptance, queue the expected bundle, apply write-back.
    always @(posedge clk) begin : model
        bundle_t e;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                exp_q[k].delete();
                for (int r = 0; r < 32; r++) mregs[k][r] = 64'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (flush) begin
                    exp_q[k].delete();
                end else if (in_valid && exp_q[k].size() == 0) begin
                    e.opcode = inst[6:0];
                    e.rd     = inst[11:7];
                    e.func3  = inst[14:12];
                    e.func7  = inst[31:25];
                    e.rs1    = inst[19:15];
                    e.rs2    = inst[24:20];
                    e.data1  = read_op(k, inst[19:15]);
                    e.data2  = read_op(k, inst[24:20]);
                    e.imm    = fit(k, ref_imm(inst));
                    exp_q[k].push_back(e);
                end
                if (wr_ok(k)) mregs[k][wb_rd] = fit(k, wb_data);
            end
        end
    end

    // Monitor: compare presented bundle with the queue head; pop on handshake.
    always @(negedge clk) begin : monitor
        for (int k = 0; k < 2; k++) begin
            chk("in_ready", k, 256'(rdy[k]),
                256'(rst && (exp_q[k].size() == 0 || out_ready)));
            chk("out_valid", k, 256'(vld[k]), 256'(exp_q[k].size() != 0));
            if (vld[k] && exp_q[k].size() != 0) begin
                chk("bundle", k, 256'(obs[k]), 256'(exp_q[k][0]));
                if (out_ready) void'(exp_q[k].pop_front());
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic [31:0] i,
                         input logic fl, input logic we, input logic [4:0] wr,
                         input logic [63:0] wd, input logic ordy);
        rst = r; in_valid = v; inst = i; flush = fl;
        wb_en = we; wb_rd = wr; wb_data = wd; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [6:0]  ops [12];
        logic [31:0] ri;
        logic [4:0]  rwr;
        ops[0] = 7'b0000011; ops[1] = 7'b0010011; ops[2]  = 7'b0011011; ops[3]  = 7'b1100111;
        ops[4] = 7'b1110011; ops[5] = 7'b0100011; ops[6]  = 7'b1100011; ops[7]  = 7'b0110111;
        ops[8] = 7'b0010111; ops[9] = 7'b1101111; ops[10] = 7'b0110011; ops[11] = 7'b0000000;

        rst = 1'b0; in_valid = 1'b0; inst = '0; flush = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;

        // Reset, then write x5 and decode addi x6,x5,5.
        drive(0, 0, 32'h0, 0, 1, 5'd3, 64'h55, 1);
        drive(0, 0, 32'h0, 0, 0, 0, 0, 1);
        drive(1, 0, 32'h0, 0, 1, 5'd5, 64'h1234, 1);
        drive(1, 1, 32'h00528313, 0, 0, 0, 0, 1);
        // addi x1,x0,-1 with a write to x0, then read x0.
        drive(1, 1, 32'hFFF00093, 0, 1, 5'd0, 64'd7, 1);
        drive(1, 1, 32'h00700113, 0, 0, 0, 0, 1);
        // Stall three cycles with a waiting instruction, then release.
        drive(1, 1, 32'h00628393, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h00628393, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h00628393, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h00628393, 0, 0, 0, 0, 1);
        drive(1, 0, 32'h0, 0, 0, 0, 0, 1);
        // Same-cycle write-back to the register being read.
        drive(1, 0, 32'h0, 0, 1, 5'd5, 64'd3, 1);
        drive(1, 1, 32'h00028413, 0, 1, 5'd5, 64'd9, 1);
        drive(1, 1, 32'h00028493, 0, 0, 0, 0, 1);
        // Flush with an incoming instruction.
        drive(1, 1, 32'h00100513, 1, 0, 0, 0, 1);
        drive(1, 0, 32'h0, 0, 0, 0, 0, 1);
        // Reset while a bundle is held, then read x5 back.
        drive(1, 1, 32'h00028593, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h00028613, 0, 1, 5'd5, 64'd77, 0);
        drive(1, 1, 32'h00028693, 0, 0, 0, 0, 1);
        // Write/read x20 (outside 16-register file) and a negative branch offset.
        drive(1, 0, 32'h0, 0, 1, 5'd20, 64'hABCD, 1);
        drive(1, 1, 32'h000A0093, 0, 0, 0, 0, 1);
        drive(1, 1, 32'hFE000CE3, 0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            ri = $urandom;
            ri[6:0] = ops[$urandom_range(0, 11)];
            rwr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) ri[19:15] = rwr;
            if ($urandom_range(0, 4) == 0) ri[24:20] = rwr;
            drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) < 7), ri,
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1), rwr,
                  {$urandom, $urandom}, ($urandom_range(0, 9) < 7));
        end

        for (int n = 0; n < 4; n++) drive(1, 0, 32'h0, 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_decode_pipe.md
ID_DECODE_PIPE -- requirements
Module: id_decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, register and immediate data width (32 or 64).
REQ-002 SHALL have parameter NREG, default 32, architectural register count (16 or 32).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept an instruction.
REQ-007 SHALL have port inst  input  32  instruction word.
REQ-008 SHALL have port flush  input  1  discard held and incoming instruction.
REQ-009 SHALL have port wb_en  input  1  write-back enable.
REQ-010 SHALL have port wb_rd  input  5  write-back destination register.
REQ-011 SHALL have port wb_data  input  XLEN  write-back data.
REQ-012 SHALL have port out_valid  output  1  decoded bundle valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts bundle.
REQ-014 SHALL have ports opcode(7), rd(5), func3(3), func7(7), rs1_addr(5), rs2_addr(5), all outputs, registered instruction fields.
REQ-015 SHALL have ports data1, data2, imm_ext, outputs, XLEN each: rs1/rs2 operands, extended immediate.

Function
REQ-016 SHALL drive in_ready = rst & (~out_valid | out_ready), combinationally; accept occurs when in_valid & in_ready.
REQ-017 SHALL, on accept without flush, set out_valid=1 and load all output fields the next cycle (latency 1).
REQ-018 SHALL clear out_valid the next cycle when out_valid & out_ready and no new accept.
REQ-019 SHALL hold every output stable while out_valid & ~out_ready.
REQ-020 SHALL, on flush, clear out_valid next cycle; flush dominates any same-cycle accept, which is discarded.
REQ-021 SHALL hold NREG x XLEN registers; write wb_data to wb_rd at clock edge when wb_en, wb_rd != 0 and wb_rd < NREG.
REQ-022 SHALL read register 0 and any address >= NREG as zero; such writes are ignored.
REQ-023 SHALL sample data1/data2 from rs1 = inst[19:15], rs2 = inst[24:20] at accept time.
REQ-024 SHALL perform write-back regardless of flush, stall or out_valid state.
REQ-025 SHALL form imm_ext by opcode: I (0000011, 0010011, 0011011, 1100111, 1110011) inst[31:20]; S (0100011) {inst[31:25],inst[11:7]}; B (1100011) {inst[31],inst[7],inst[30:25],inst[11:8],0}; U (0110111, 0010111) {inst[31:12],12'b0}; J (1101111) {inst[31],inst[19:12],inst[20],inst[30:21],0}; all sign-extended to XLEN; other opcodes 0.
REQ-026 SHALL register opcode=inst[6:0], rd=inst[11:7], func3=inst[14:12], func7=inst[31:25] unconditionally of opcode type.

Reset
REQ-027 SHALL, when rst=0 at a rising edge, clear out_valid, all output fields and all registers to 0.
REQ-028 SHALL hold in_ready=0 while rst=0; an instruction held mid-operation is discarded.
REQ-029 SHALL ignore wb_en during reset cycles.

Configuration
REQ-030 SHALL recognise macro ID_WB_BYPASS_EN.
REQ-031 SHALL, with ID_WB_BYPASS_EN defined, forward wb_data to data1/data2 when a same-cycle write (per REQ-021) targets the register being read at accept.
REQ-032 SHALL, without ID_WB_BYPASS_EN, load the pre-write register value in that case; the write still completes.

Verification
REQ-033 SHALL cover: reset, then wb x5=64'h1234 then accept inst 32'h00528313 (addi x6,x5,5) -> next cycle out_valid=1, data1=64'h1234, imm_ext=5, rd=6, opcode=0010011.
REQ-034 SHALL cover: accept 32'hFFF00093 (addi x1,x0,-1) -> imm_ext=64'hFFFF_FFFF_FFFF_FFFF, data1=0; wb x0=7 then read x0 -> data1=0.
REQ-035 SHALL cover: out_ready=0 with out_valid=1 for 3 cycles -> in_ready=0, outputs unchanged; out_ready=1 -> next instruction accepted that cycle.
REQ-036 SHALL cover: wb x5=9 in the same cycle as accept reading x5 (old 3) -> data1=9 with ID_WB_BYPASS_EN, 3 without; later read returns 9.
REQ-037 SHALL cover: flush asserted with in_valid=1 -> out_valid=0 next cycle; rst=0 while out_valid=1 -> out_valid=0, all regs 0.
REQ-038 SHALL cover: NREG=16, XLEN=32 -> wb x20 ignored, read x20 = 0, beq offset -8 (32'hFE000CE3) gives imm_ext=32'hFFFF_FFF8.
